merge21: RTL

- Two-input to one-output merge/arbiter for the async-NoC router datapath.
- It is the inverse of the 1-to-2 address decoder: it accepts flits from In0 and In1 and arbitrates between them with round-robin fairness.
- It forwards each granted flit unchanged on Out.
- It reports on S which input won, so a downstream decoder or monitor can track path provenance.
- It runs inside the clocked RTL body behind the standard channel SEND/RECV wrappers; every channel is a valid/ready handshake.

---
 rtl/merge21.sv | 112 +++++++++++
 1 files changed

// File: rtl/merge21.sv
// Two-input to one-output round-robin merge. Each granted flit is held in a
// register, then sent on Out while the winning input index is sent on S.
module merge21 #(
   parameter int W         = 9,
   parameter bit INIT_PRIO = 1'b0
) (
   input  logic         CLK,
   input  logic         _RESET,
   input  logic [W-1:0] In0_data,
   input  logic         In0_valid,
   output logic         In0_ready,
   input  logic [W-1:0] In1_data,
   input  logic         In1_valid,
   output logic         In1_ready,
   output logic [W-1:0] Out_data,
   output logic         Out_valid,
   input  logic         Out_ready,
   output logic         S_data,
   output logic         S_valid,
   input  logic         S_ready
);

   // Handshake: a transfer happens on a channel at every rising CLK edge where
   // valid && ready. A source holds data stable while valid is high and the
   // transfer has not yet happened; ready never depends on a later edge.

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic         prio_q, prio_d;
   logic         sel_q, sel_d;
   logic         out_done_q, out_done_d;
   logic         s_done_q, s_done_d;
   logic [W-1:0] flit_q, flit_d;
   logic         grant;
   logic         any_valid;
   logic         out_fire;
   logic         s_fire;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state_q    <= IDLE;
         prio_q     <= INIT_PRIO;
         sel_q      <= 1'b0;
         out_done_q <= 1'b0;
         s_done_q   <= 1'b0;
         flit_q     <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         sel_q      <= sel_d;
         out_done_q <= out_done_d;
         s_done_q   <= s_done_d;
         flit_q     <= flit_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      sel_d      = sel_q;
      out_done_d = out_done_q;
      s_done_d   = s_done_q;
      flit_d     = flit_q;
      In0_ready  = 1'b0;
      In1_ready  = 1'b0;
      Out_valid  = 1'b0;
      S_valid    = 1'b0;
      out_fire   = 1'b0;
      s_fire     = 1'b0;
      any_valid  = In0_valid | In1_valid;
      // Contention goes to prio; otherwise the lone requester wins.
      grant      = (In0_valid && In1_valid) ? prio_q : In1_valid;

      case (state_q)
         IDLE: begin
            // Readies are gated by reset so nothing is accepted while held in reset.
            if (_RESET && any_valid) begin
               In0_ready  = ~grant;
               In1_ready  = grant;
               flit_d     = grant ? In1_data : In0_data;
               sel_d      = grant;
               prio_d     = ~grant;
               out_done_d = 1'b0;
               s_done_d   = 1'b0;
               state_d    = SEND;
            end
         end
         SEND: begin
            Out_valid  = ~out_done_q;
            S_valid    = ~s_done_q;
            out_fire   = Out_valid & Out_ready;
            s_fire     = S_valid & S_ready;
            out_done_d = out_done_q | out_fire;
            s_done_d   = s_done_q | s_fire;
            if (out_done_d && s_done_d) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Out_data = flit_q;
   assign S_data   = sel_q;

endmodule
